// File: rtl/fifo_drain_rr_pkg.sv
// Shared types for the egress FIFO drain block.
// FSM state encodings and lane geometry.
package fifo_drain_rr_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_drain_rr_arb.sv
// Round-robin arbiter over four request lanes.
// Pointer advances past the winner only when a grant is issued.
module rr_arbiter4
  import fifo_drain_rr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] req,
  output logic [NUM_LANES-1:0] grant,
  output logic [LANE_W-1:0]    grant_idx
);

  logic [LANE_W-1:0] ptr;
  logic              found;

  always_comb begin
    found     = 1'b0;
    grant_idx = ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!found && req[ptr + LANE_W'(i)]) begin
        found     = 1'b1;
        grant_idx = ptr + LANE_W'(i);
      end
    end
    grant = '0;
    if (en && found)
      grant = NUM_LANES'(1) << grant_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (|grant)
      ptr <= grant_idx + LANE_W'(1);
  end

endmodule

// File: rtl/fifo_drain_rr.sv
// Round-robin drain of four egress FIFOs into a credit-limited
// output queue, with per-lane delivered-word counters.
module fifo_drain_rr
  import fifo_drain_rr_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 3,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            empty_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic [3:0]            pop_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            lane_out,
  output logic                  valid_out,
  input  logic                  rdy_in,
  input  logic                  cnt_clr,
  input  logic [1:0]            cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_out,
  output logic                  idle_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 2);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] din   [NUM_LANES];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [LANE_W-1:0]     mem_l [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt   [NUM_LANES];

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [OW-1:0]     count, outstanding;
  logic              in_flight, xfer, can_pop;
  logic [LANE_W-1:0] if_lane, grant_idx;
  logic [3:0]        grant;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  assign valid_out = (count != '0);
  assign xfer      = valid_out & rdy_in;
  assign data_out  = valid_out ? mem_d[rd_ptr] : '0;
  assign lane_out  = valid_out ? mem_l[rd_ptr] : '0;

  // A word leaving this cycle frees its slot for a same-cycle pop.
  assign outstanding = OW'(in_flight) + count - OW'(xfer);
  assign can_pop = (state == RUN) && enable &&
                   (outstanding < OW'(DEPTH));

  rr_arbiter4 u_arb (
    .clk       (clk),
    .rst       (reset),
    .en        (can_pop),
    .req       (~empty_in),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign pop_out  = grant;
  assign idle_out = (state == IDLE);
  assign cnt_out  = cnt[cnt_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      in_flight <= 1'b0;
      if_lane   <= '0;
    end else begin
      if (in_flight)
        wr_ptr <= inc(wr_ptr);
      if (xfer)
        rd_ptr <= inc(rd_ptr);
      count     <= count + OW'(in_flight) - OW'(xfer);
      in_flight <= |grant;
      if (|grant)
        if_lane <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (in_flight) begin
      mem_d[wr_ptr] <= din[if_lane];
      mem_l[wr_ptr] <= if_lane;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++)
        cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_LANES; i++)
        cnt[i] <= '0;
    end else if (xfer) begin
      cnt[lane_out] <= cnt[lane_out] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (enable)
          state_nxt = RUN;
      RUN:
        if (!enable)
          state_nxt = (outstanding != '0) ? DRAIN : IDLE;
      DRAIN:
        if (enable)
          state_nxt = RUN;
        else if (outstanding == '0)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  ovf_chk: assert property (@(posedge clk) disable iff (reset)
    !(in_flight && !xfer && count == OW'(DEPTH)));

endmodule

// File: tb/tb_fifo_drain_rr.sv
// Directed bench for fifo_drain_rr with a queue-based reference
// model of the drain, egress FIFOs and counters.
module tb_fifo_drain_rr;

  logic       clk = 1'b0;
  logic       reset, enable, rdy_in, cnt_clr;
  logic [3:0] empty_in;
  logic [9:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0] pop_out;
  logic [9:0] data_out;
  logic [1:0] lane_out, cnt_sel;
  logic       valid_out, idle_out;
  logic [4:0] cnt_out;

  fifo_drain_rr dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .empty_in  (empty_in),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .pop_out   (pop_out),
    .data_out  (data_out),
    .lane_out  (lane_out),
    .valid_out (valid_out),
    .rdy_in    (rdy_in),
    .cnt_clr   (cnt_clr),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .idle_out  (idle_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int fq [4][$];
  logic [9:0] dreg [4];

  int m_st, m_ptr, m_inf, m_iflane;
  int m_q [$];
  int m_cnt [4];

  int pop_log [$];
  int pop_cyc [$];
  int xf_log [$];
  int xf_cyc [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply_env();
    for (int l = 0; l < 4; l++)
      empty_in[l] = (fq[l].size() == 0);
    data_in0 = dreg[0];
    data_in1 = dreg[1];
    data_in2 = dreg[2];
    data_in3 = dreg[3];
  endtask

  task automatic model_reset();
    m_st = 0;
    m_ptr = 0;
    m_inf = 0;
    m_iflane = 0;
    m_q.delete();
    for (int l = 0; l < 4; l++)
      m_cnt[l] = 0;
  endtask

  // Per-cycle reference step: predict, compare, then advance.
  task automatic cycle();
    int plane, outst, e, hl;
    bit vld, xf;
    @(negedge clk);
    if (reset) begin
      model_reset();
      chk("rst_pop", pop_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_lane", lane_out, 0);
      chk("rst_idle", idle_out, 1);
      chk("rst_cnt", cnt_out, 0);
    end else begin
      vld = (m_q.size() > 0);
      xf = vld && rdy_in;
      outst = m_inf + m_q.size() - (xf ? 1 : 0);
      plane = -1;
      if (m_st == 1 && enable && outst < 3)
        for (int i = 0; i < 4; i++)
          if (plane < 0 && !empty_in[(m_ptr + i) % 4])
            plane = (m_ptr + i) % 4;
      chk("pop", pop_out, plane < 0 ? 0 : (1 << plane));
      chk("valid", valid_out, vld);
      if (vld) begin
        e = m_q[0];
        chk("data", data_out, e & 'h3FF);
        chk("lane", lane_out, e >> 10);
      end
      chk("cnt", cnt_out, m_cnt[cnt_sel]);
      chk("idle", idle_out, m_st == 0);
      for (int l = 0; l < 4; l++)
        if (pop_out[l]) begin
          pop_log.push_back(l);
          pop_cyc.push_back(cyc);
        end
      if (valid_out && rdy_in) begin
        xf_log.push_back((int'(lane_out) << 10) | int'(data_out));
        xf_cyc.push_back(cyc);
      end
      if (cnt_clr) begin
        for (int l = 0; l < 4; l++)
          m_cnt[l] = 0;
      end else if (xf) begin
        hl = m_q[0] >> 10;
        m_cnt[hl] = (m_cnt[hl] + 1) % 32;
      end
      if (xf)
        void'(m_q.pop_front());
      if (m_inf != 0)
        m_q.push_back((m_iflane << 10) | int'(dreg[m_iflane]));
      m_inf = (plane >= 0);
      if (plane >= 0) begin
        m_iflane = plane;
        m_ptr = (plane + 1) % 4;
        dreg[plane] = 10'(fq[plane].pop_front());
      end
      case (m_st)
        0: if (enable) m_st = 1;
        1: if (!enable) m_st = (outst > 0) ? 2 : 0;
        default:
          if (enable) m_st = 1;
          else if (outst == 0) m_st = 0;
      endcase
    end
    @(posedge clk);
    #1;
    apply_env();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cycle();
  endtask

  task automatic load(input int lane, input int w);
    fq[lane].push_back(w);
    apply_env();
  endtask

  task automatic clr_logs();
    pop_log.delete();
    pop_cyc.delete();
    xf_log.delete();
    xf_cyc.delete();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rdy_in = 1'b0;
    cnt_clr = 1'b0;
    reset = 1'b1;
    for (int l = 0; l < 4; l++)
      fq[l].delete();
    apply_env();
    run(2);
    reset = 1'b0;
    clr_logs();
  endtask

  int base;

  initial begin
    for (int l = 0; l < 4; l++)
      dreg[l] = '0;
    reset = 1'b1;
    enable = 1'b0;
    rdy_in = 1'b0;
    cnt_clr = 1'b0;
    cnt_sel = 2'd0;
    apply_env();
    model_reset();
    run(2);
    reset = 1'b0;
    run(1);

    // Two words on lane 2.
    clr_logs();
    load(2, 'h2A1);
    load(2, 'h2A2);
    rdy_in = 1'b1;
    enable = 1'b1;
    base = cyc;
    run(8);
    chk("t1_npop", pop_log.size(), 2);
    chk("t1_nxf", xf_log.size(), 2);
    if (pop_log.size() == 2 && xf_log.size() == 2) begin
      chk("t1_pop0", pop_log[0], 2);
      chk("t1_pop1", pop_log[1], 2);
      chk("t1_popc0", pop_cyc[0], base + 1);
      chk("t1_popc1", pop_cyc[1], base + 2);
      chk("t1_w0", xf_log[0], 'hAA1);
      chk("t1_w1", xf_log[1], 'hAA2);
      chk("t1_xc0", xf_cyc[0], base + 3);
      chk("t1_xc1", xf_cyc[1], base + 4);
    end
    cnt_sel = 2'd2;
    #1;
    chk("t1_cnt2", cnt_out, 2);

    // Four lanes, three words each: strict rotation.
    do_reset();
    for (int k = 1; k <= 3; k++)
      for (int l = 0; l < 4; l++)
        load(l, (l << 8) | k);
    enable = 1'b1;
    rdy_in = 1'b1;
    run(20);
    chk("t2_npop", pop_log.size(), 12);
    for (int i = 0; i < 12 && i < pop_log.size(); i++)
      chk("t2_order", pop_log[i], i % 4);
    chk("t2_nxf", xf_log.size(), 12);

    // Backpressure: credit caps pops at DEPTH.
    do_reset();
    for (int k = 1; k <= 3; k++)
      for (int l = 0; l < 4; l++)
        load(l, (l << 8) | k);
    enable = 1'b1;
    run(10);
    chk("t3_npop", pop_log.size(), 3);
    chk("t3_vld", valid_out, 1);
    chk("t3_head", data_out, 'h001);
    rdy_in = 1'b1;
    run(25);
    chk("t3_npop2", pop_log.size(), 12);
    if (xf_log.size() >= 3) begin
      chk("t3_x0", xf_log[0], 'h001);
      chk("t3_x1", xf_log[1], 'h501);
      chk("t3_x2", xf_log[2], 'hA01);
    end else begin
      chk("t3_nxf", xf_log.size(), 12);
    end

    // Drop enable with two words outstanding.
    do_reset();
    for (int k = 1; k <= 5; k++)
      load(1, 'h100 | k);
    enable = 1'b1;
    run(3);
    enable = 1'b0;
    run(1);
    chk("t4_busy", idle_out, 0);
    rdy_in = 1'b1;
    base = cyc;
    run(1);
    chk("t4_busy2", idle_out, 0);
    run(1);
    chk("t4_idle", idle_out, 1);
    chk("t4_npop", pop_log.size(), 2);
    chk("t4_nxf", xf_log.size(), 2);
    if (xf_log.size() == 2) begin
      chk("t4_w0", xf_log[0], 'h501);
      chk("t4_w1", xf_log[1], 'h502);
      chk("t4_lastc", xf_cyc[1], base + 1);
    end
    run(3);
    chk("t4_nopop", pop_log.size(), 2);

    // Counter wrap and clear-versus-transfer.
    do_reset();
    cnt_sel = 2'd1;
    for (int k = 1; k <= 33; k++)
      load(1, 'h100 | (k & 'hFF));
    enable = 1'b1;
    rdy_in = 1'b1;
    run(40);
    chk("t5_nxf", xf_log.size(), 33);
    chk("t5_wrap", cnt_out, 1);
    load(1, 'h1F0);
    base = cyc;
    run(2);
    cnt_clr = 1'b1;
    run(1);
    cnt_clr = 1'b0;
    #1;
    chk("t5_clr", cnt_out, 0);
    chk("t5_xc", xf_cyc[xf_cyc.size() - 1], base + 2);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int k = 1; k <= 4; k++)
      load(2, 'h200 | k);
    enable = 1'b1;
    rdy_in = 1'b1;
    run(4);
    chk("t6_pop", pop_out, 4);
    chk("t6_vld", valid_out, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_apop", pop_out, 0);
    chk("t6_avld", valid_out, 0);
    chk("t6_aidle", idle_out, 1);
    run(2);
    reset = 1'b0;
    #1;
    chk("t6_empty", valid_out, 0);
    cnt_sel = 2'd2;
    #1;
    chk("t6_cnt2", cnt_out, 0);
    clr_logs();
    load(0, 'h0C1);
    load(3, 'h3C1);
    run(10);
    chk("t6_npop", pop_log.size(), 3);
    if (pop_log.size() > 0)
      chk("t6_first", pop_log[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_rr.md
Name: fifo_drain_rr

Overview:
- Reader-side counterpart of the switch's output FIFOs (the four egress FIFOs written by the arbiter/demux path).
- Pops the four egress FIFOs with round-robin fairness and buffers the words in a small credit-controlled output queue.
- Presents a single valid/ready stream tagged with the source lane.
- Keeps per-lane delivered-word counters readable through a select port.

Parameters:
- DATA_WIDTH, 10, word width; bits [9:8] carry the destination lane.
- DEPTH, 3, output queue entries; also the maximum outstanding words (in-flight plus queued).
- CNT_WIDTH, 5, width of each per-lane delivered-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new pops when high.
- empty_in  in  4  empty flags of egress FIFOs 0..3.
- data_in0..data_in3  in  DATA_WIDTH each  registered read data of egress FIFOs 0..3.
- pop_out  in→out  4  one-hot pop to egress FIFOs 0..3 (output).
- data_out  out  DATA_WIDTH  head word of the output queue.
- lane_out  out  2  source lane of data_out.
- valid_out  out  1  data_out/lane_out valid.
- rdy_in  in  1  downstream accepts; transfer occurs when valid_out and rdy_in are both high at a rising edge.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_sel  in  2  counter select.
- cnt_out  out  CNT_WIDTH  counter of the lane selected by cnt_sel (combinational mux).
- idle_out  out  1  high in state IDLE.

Behaviour:
- Reset is asynchronous and active-high. Reset forces:
  - pop_out=0, valid_out=0, data_out=0, lane_out=0.
  - Queue emptied; any in-flight word discarded.
  - Round-robin pointer=0, all counters=0, state=IDLE, idle_out=1.
  - pop_out drops immediately on reset assertion, not at the next edge.
- FIFO timing (fixed):
  - Read data for a pop asserted in cycle t is on data_in[lane] during t+1.
  - empty_in reflects that pop from cycle t+1.
- Pop issue in cycle t requires all of:
  - state RUN;
  - outstanding < DEPTH, where outstanding = in_flight (0/1) + queue occupancy − (1 if a transfer completes this cycle);
  - at least one lane with empty_in=0.
- At most one pop bit is high per cycle, so pop_out is always one-hot or zero.
- Round-robin arbitration:
  - Search lanes ptr, ptr+1, … mod 4; the first lane with empty_in=0 wins.
  - After a pop, ptr = winner+1 mod 4. ptr is unchanged when no pop is issued.
- Capture: in cycle t+1, data_in[lane] and the lane number are written into the queue tail at the rising edge ending t+1.
- Latency: pop to earliest valid_out is 2 cycles.
- With rdy_in held high and a single lane non-empty, sustained throughput is one word per cycle (DEPTH=3).
- Queue behaviour:
  - FIFO ordering.
  - Simultaneous write and read in the same cycle is legal and leaves occupancy unchanged.
  - The credit rule guarantees the queue never overflows. Overflow is a design error, to be caught by an assertion.
- data_out and lane_out hold stable while valid_out=1 and rdy_in=0.
- Counter update:
  - counter[lane_out] increments on each transfer and wraps 31→0.
  - cnt_clr clears all counters. If cnt_clr and a transfer coincide, the clear wins and the counter ends at 0.
- FSM transitions:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0 and outstanding>0.
  - RUN → IDLE when enable=0 and outstanding=0.
  - DRAIN → RUN when enable=1.
  - DRAIN → IDLE when outstanding reaches 0.
- In DRAIN, no pops are issued, but queued and in-flight words are still delivered.
- No pops are ever issued to a lane whose empty_in=1.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - NUM_LANES=4;
  - the lane-index width (2).
- Natural sub-module: rr_arbiter4 (pointer register plus first-non-empty search, one-hot grant).
- The output queue and counters stay inline.

Test Plan:
- Reset, then enable=1 with lane 2 holding words 0x2A1, 0x2A2 and rdy_in=1:
  - pop_out=4'b0100 in two consecutive cycles;
  - valid_out with 0x2A1, lane_out=2 appears 2 cycles after the first pop, and 0x2A2 follows on the next cycle;
  - counter[2]=2.
- All four lanes each hold 3 words, rdy_in=1: pop order is lanes 0,1,2,3,0,1,2,3,0,1,2,3, with no lane popped twice before the others.
- rdy_in=0 with lanes full:
  - exactly DEPTH=3 pops are issued, then pop_out stays 0;
  - data_out stays stable;
  - raising rdy_in drains the words in order and pops resume.
- enable dropped with 2 words outstanding:
  - state goes to DRAIN, no new pops, both words are delivered;
  - idle_out rises the cycle after the last transfer.
- 33 words from lane 1 with cnt_sel=1: cnt_out wraps and reads 1. Asserting cnt_clr in the same cycle as a transfer leaves cnt_out at 0.
- Asynchronous reset asserted while a pop is in flight:
  - pop_out and valid_out fall immediately;
  - after release, the queue is empty, counters read 0, and ptr restarts at lane 0.
